onehot_priority_arbiter: RTL and testbench



---
 rtl/onehot_arb_pkg.sv | 31 +++
 rtl/prio_level_cmp.sv | 22 ++
 rtl/onehot_priority_arbiter.sv | 120 ++++++++++++
 tb/tb_onehot_priority_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/onehot_arb_pkg.sv
// Shared types and helpers for the one-hot priority arbiter: FSM state,
// level comparison codes and highest-set-bit reduction.
package onehot_arb_pkg;

   localparam int MAX_PRIO_W = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      CMP_EQ   = 2'b00,
      CMP_A_HI = 2'b01,
      CMP_B_HI = 2'b10
   } cmp_t;

   // Keeps only the highest set bit, so a malformed level collapses to one-hot.
   function automatic logic [MAX_PRIO_W-1:0] hi_bit(input logic [MAX_PRIO_W-1:0] prio);
      logic [MAX_PRIO_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_PRIO_W; i++) begin
         if (prio[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_level_cmp.sv
// Compares two reduced one-hot priority levels; an all-zero level ranks lowest.
module prio_level_cmp
   import onehot_arb_pkg::*;
#(
   parameter int PRIO_W = 4
) (
   input  logic [PRIO_W-1:0] a_i,
   input  logic [PRIO_W-1:0] b_i,
   output cmp_t              cmp_o
);

   // A higher one-hot bit is also a larger unsigned value.
   always_comb begin
      cmp_o = CMP_EQ;
      if (a_i > b_i) begin
         cmp_o = CMP_A_HI;
      end else if (b_i > a_i) begin
         cmp_o = CMP_B_HI;
      end
   end

endmodule

// File: rtl/onehot_priority_arbiter.sv
// N-way arbiter: highest one-hot level wins, ties broken round-robin from ptr,
// grant held until release with zero-bubble re-arbitration.
module onehot_priority_arbiter
   import onehot_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PRIO_W  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*PRIO_W-1:0] prio_i,
   input  logic                      release_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      grant_valid_o,
   output logic [PRIO_W-1:0]         grant_prio_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0][PRIO_W-1:0] level;
   logic [PRIO_W-1:0]              max_lvl;
   logic [NUM_REQ-1:0]             cand;
   logic [NUM_REQ-1:0]             masked;
   logic [NUM_REQ-1:0]             pick;
   logic [IDX_W-1:0]               win_idx;
   logic                           any_elig;

   state_e                         state_q, state_d;
   logic [NUM_REQ-1:0]             grant_q, grant_d;
   logic                           valid_q, valid_d;
   logic [PRIO_W-1:0]              prio_q, prio_d;
   logic [IDX_W-1:0]               ptr_q, ptr_d;

   // A non-requesting input contributes level zero, i.e. is never eligible.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_level
      assign level[i] = req_i[i]
         ? PRIO_W'(hi_bit(MAX_PRIO_W'(prio_i[i*PRIO_W +: PRIO_W])))
         : '0;
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_max
      logic [PRIO_W-1:0] mx;
      if (i == 0) begin : g_first
         assign mx = level[0];
      end else begin : g_next
         cmp_t c;
         prio_level_cmp #(.PRIO_W(PRIO_W)) u_cmp (
            .a_i   (g_max[i-1].mx),
            .b_i   (level[i]),
            .cmp_o (c)
         );
         assign mx = (c == CMP_B_HI) ? level[i] : g_max[i-1].mx;
      end
   end

   assign max_lvl = g_max[NUM_REQ-1].mx;

   // Prefer the lowest candidate at or above ptr, else wrap to the lowest overall.
   always_comb begin
      cand    = '0;
      masked  = '0;
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand[i]   = (|level[i]) && (level[i] == max_lvl);
         masked[i] = cand[i] && (IDX_W'(i) >= ptr_q);
      end
      pick = (|masked) ? masked : cand;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pick[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   assign any_elig = |cand;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      valid_d = valid_q;
      prio_d  = prio_q;
      ptr_d   = ptr_q;
      if ((state_q == IDLE) || release_i) begin
         if (any_elig) begin
            state_d = GRANT;
            grant_d = NUM_REQ'(1) << win_idx;
            valid_d = 1'b1;
            prio_d  = level[win_idx];
            ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            prio_d  = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         valid_q <= 1'b0;
         prio_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         prio_q  <= prio_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_valid_o = valid_q;
   assign grant_prio_o  = prio_q;

endmodule

// File: tb/tb_onehot_priority_arbiter.sv
// Directed vector bench for onehot_priority_arbiter (4 requesters, 4 levels).
module tb_onehot_priority_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] prio;
   logic        rel;
   logic [3:0]  grant;
   logic        valid;
   logic [3:0]  gprio;

   int pass_cnt  = 0;
   int check_cnt = 0;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] prio;
      logic        rel;
      logic [3:0]  exp_grant;
      logic        exp_valid;
      logic [3:0]  exp_prio;
   } vec_t;

   vec_t vecs[$];

   onehot_priority_arbiter #(.NUM_REQ(4), .PRIO_W(4)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_i         (req),
      .prio_i        (prio),
      .release_i     (rel),
      .grant_o       (grant),
      .grant_valid_o (valid),
      .grant_prio_o  (gprio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      check_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic [3:0] eg, input logic ev, input logic [3:0] ep);
      checkOutput({tag, " grant"}, 16'(grant), 16'(eg));
      checkOutput({tag, " valid"}, 16'(valid), 16'(ev));
      checkOutput({tag, " prio"}, 16'(gprio), 16'(ep));
      checkOutput({tag, " onehot0"}, 16'($onehot0(grant)), 16'd1);
      checkOutput({tag, " valid_eq_or"}, 16'(valid), 16'(|grant));
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [15:0] p, input logic rl);
      req  = r;
      prio = p;
      rel  = rl;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic void add_vec(input logic [3:0] r, input logic [15:0] p, input logic rl,
                                   input logic [3:0] eg, input logic ev, input logic [3:0] ep);
      vec_t v;
      v.req = r; v.prio = p; v.rel = rl;
      v.exp_grant = eg; v.exp_valid = ev; v.exp_prio = ep;
      vecs.push_back(v);
   endfunction

   initial begin
      // prio nibbles are {p3, p2, p1, p0}
      add_vec(4'b0100, 16'h0200, 1'b0, 4'b0100, 1'b1, 4'b0010);
      add_vec(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b1011, 16'h4081, 1'b0, 4'b0010, 1'b1, 4'b1000);
      add_vec(4'b1111, 16'h8888, 1'b0, 4'b0010, 1'b1, 4'b1000);
      add_vec(4'b1000, 16'h8000, 1'b0, 4'b0010, 1'b1, 4'b1000);
      add_vec(4'b0010, 16'h0000, 1'b0, 4'b0010, 1'b1, 4'b1000);
      add_vec(4'b0011, 16'h0018, 1'b0, 4'b0010, 1'b1, 4'b1000);
      add_vec(4'b1111, 16'hFFFF, 1'b0, 4'b0010, 1'b1, 4'b1000);
      add_vec(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b1111, 16'h4444, 1'b1, 4'b0100, 1'b1, 4'b0100);
      add_vec(4'b1111, 16'h4444, 1'b1, 4'b1000, 1'b1, 4'b0100);
      add_vec(4'b1111, 16'h4444, 1'b1, 4'b0001, 1'b1, 4'b0100);
      add_vec(4'b1111, 16'h4444, 1'b1, 4'b0010, 1'b1, 4'b0100);
      add_vec(4'b1111, 16'h4444, 1'b1, 4'b0100, 1'b1, 4'b0100);
      add_vec(4'b0100, 16'h0400, 1'b1, 4'b0100, 1'b1, 4'b0100);
      add_vec(4'b1100, 16'h2800, 1'b1, 4'b0100, 1'b1, 4'b1000);
      add_vec(4'b0011, 16'h0021, 1'b1, 4'b0010, 1'b1, 4'b0010);
      add_vec(4'b0010, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b0010, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b0010, 16'h0060, 1'b0, 4'b0010, 1'b1, 4'b0100);
      add_vec(4'b0000, 16'h8888, 1'b1, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b0001, 16'h8001, 1'b0, 4'b0001, 1'b1, 4'b0001);
      add_vec(4'b0110, 16'h0930, 1'b1, 4'b0100, 1'b1, 4'b1000);
      add_vec(4'b0000, 16'h0000, 1'b0, 4'b0100, 1'b1, 4'b1000);
      add_vec(4'b0011, 16'h0044, 1'b1, 4'b0001, 1'b1, 4'b0100);
      add_vec(4'b0011, 16'h0044, 1'b1, 4'b0010, 1'b1, 4'b0100);
      add_vec(4'b0011, 16'h0044, 1'b1, 4'b0001, 1'b1, 4'b0100);

      rst_n = 1'b0;
      req   = '0;
      prio  = '0;
      rel   = 1'b0;
      repeat (2) @(negedge clk);
      checkAll("reset", 4'b0000, 1'b0, 4'b0000);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].req, vecs[i].prio, vecs[i].rel);
         checkAll($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_valid, vecs[i].exp_prio);
      end

      // Mid-grant asynchronous reset clears outputs between edges.
      req = 4'b0000; prio = 16'h0000; rel = 1'b0;
      #2 rst_n = 1'b0;
      #1 checkAll("async_rst", 4'b0000, 1'b0, 4'b0000);

      // Requests and release during reset are overridden.
      req = 4'b1100; prio = 16'h4400; rel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkAll("rst_wins", 4'b0000, 1'b0, 4'b0000);

      // After reset the pointer restarts at 0, so requester 2 wins the tie.
      rst_n = 1'b1;
      applyStimulus(4'b1100, 16'h4400, 1'b0);
      checkAll("post_rst", 4'b0100, 1'b1, 4'b0100);
      applyStimulus(4'b1100, 16'h4400, 1'b1);
      checkAll("post_rst_rr", 4'b1000, 1'b1, 4'b0100);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
